// File: rtl/qa_drv_csr_bank_pkg.sv
// ---------------------------------------------------------------------------
// qa_drv_csr_bank_pkg
//   Shared definitions for the driver-side CSR bank: data/address widths,
//   the pulse record type, the address-match helper and the helpers that
//   compute the byte address of every CSR in the bank.
//
//   The bank uses this byte address map (base = CSR_BASE):
//     reg i low   : base + 8*i
//     reg i high  : base + 8*i + 4
//     enable      : base + 8*N_REG64
//     pulse j     : base + 8*N_REG64 + 4 + 4*j
// ---------------------------------------------------------------------------
package qa_drv_csr_bank_pkg;

  localparam int CSR_DATA_W  = 32;
  localparam int CSR_HDR_W   = 18;
  localparam int CSR_DWADR_W = 14;
  localparam int PULSE_W_MAX = 32;

  // One pulse CSR: strobe qualifies a payload that lives for a single cycle.
  // The payload is carried at full bus width; the bank trims it to PULSE_W.
  typedef struct packed {
    logic                   strobe;
    logic [PULSE_W_MAX-1:0] payload;
  } t_CSR_PULSE;

  // The CCI header carries a dword address, so it is compared against the
  // byte address with the two byte-offset bits dropped.
  function automatic logic csr_addr_match(input logic [CSR_DWADR_W-1:0] dw_addr,
                                          input logic [15:0]            byte_addr);
    return dw_addr == CSR_DWADR_W'(byte_addr >> 2);
  endfunction

  function automatic logic [15:0] reg_lo_offset(input logic [15:0] base, input int idx);
    return base + 16'(idx * 8);
  endfunction

  function automatic logic [15:0] reg_hi_offset(input logic [15:0] base, input int idx);
    return base + 16'(idx * 8 + 4);
  endfunction

  function automatic logic [15:0] enable_offset(input logic [15:0] base, input int n_reg);
    return base + 16'(n_reg * 8);
  endfunction

  function automatic logic [15:0] pulse_offset(input logic [15:0] base, input int n_reg,
                                               input int idx);
    return base + 16'(n_reg * 8 + 4 + idx * 4);
  endfunction

endpackage

// File: rtl/qa_drv_csr_bank_pair.sv
// ---------------------------------------------------------------------------
// qa_drv_csr_pair
//   One 64-bit CSR written as two 32-bit halves. The low half is parked in
//   a staging register; the high-half write commits both halves at once so
//   software never observes a torn 64-bit value.
//
// Ports
//   clk        in   clock, all state on rising edge
//   reset      in   asynchronous active-high reset
//   lo_we      in   write strobe for the low half
//   hi_we      in   write strobe for the high half (commit)
//   soft_clear in   drops the committed flag, value is kept
//   wr_data    in   32-bit write data
//   value      out  committed 64-bit value
//   valid      out  set by a commit, cleared by a low write or soft_clear
// ---------------------------------------------------------------------------
module qa_drv_csr_pair
  import qa_drv_csr_bank_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    lo_we,
  input  logic                    hi_we,
  input  logic                    soft_clear,
  input  logic [CSR_DATA_W-1:0]   wr_data,
  output logic [2*CSR_DATA_W-1:0] value,
  output logic                    valid
);

  logic [CSR_DATA_W-1:0]   low_stage_d, low_stage_q;
  logic [2*CSR_DATA_W-1:0] value_d,     value_q;
  logic                    valid_d,     valid_q;

  // Next-state for the staging register, committed value and valid flag.
  // A low write invalidates the register because a new 64-bit value is now
  // in flight; soft_clear overrides a simultaneous commit for the flag only.
  always_comb begin
    low_stage_d = low_stage_q;
    value_d     = value_q;
    valid_d     = valid_q;

    if (lo_we) begin
      low_stage_d = wr_data;
      valid_d     = 1'b0;
    end

    if (hi_we) begin
      value_d = {wr_data, low_stage_q};
      valid_d = 1'b1;
    end

    if (soft_clear) begin
      valid_d = 1'b0;
    end
  end

  // State register; reset also discards any half-written low value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      low_stage_q <= '0;
      value_q     <= '0;
      valid_q     <= 1'b0;
    end else begin
      low_stage_q <= low_stage_d;
      value_q     <= value_d;
      valid_q     <= valid_d;
    end
  end

  assign value = value_q;
  assign valid = valid_q;

endmodule

// File: rtl/qa_drv_csr_bank.sv
// ---------------------------------------------------------------------------
// qa_drv_csr_bank
//   Driver-facing CSR bank fed by CCI MMIO writes. Holds N_REG64 split 64-bit
//   registers, a single enable bit, N_PULSE one-cycle pulse CSRs, and a
//   saturating count of writes that hit no CSR. Every output is a flop, so
//   each write becomes visible exactly one cycle later.
//
// Ports
//   clk           in   clock
//   reset         in   asynchronous active-high reset
//   rx_csr_valid  in   write strobe, one write per asserted cycle
//   rx_csr_header in   CCI header, [13:0] dword address, [17:14] ignored
//   rx_csr_data   in   32-bit write data
//   soft_clear    in   clears every reg_valid bit and afu_en
//   reg_value     out  N_REG64 committed 64-bit values, reg i at [64i +: 64]
//   reg_valid     out  per-register committed flag
//   afu_en        out  enable bit
//   pulse_value   out  pulse payloads, pulse j at [PULSE_W*j +: PULSE_W]
//   pulse_strobe  out  one-cycle qualifier per pulse CSR
//   unmatched_cnt out  saturating count of writes matching no CSR
//
// With N_PULSE = 0 the pulse ports keep a width of one and stay at zero.
// ---------------------------------------------------------------------------
module qa_drv_csr_bank
  import qa_drv_csr_bank_pkg::*;
#(
  parameter int          N_REG64  = 4,
  parameter int          N_PULSE  = 2,
  parameter int          PULSE_W  = 8,
  parameter logic [15:0] CSR_BASE = 16'h1a00
) (
  input  logic                                          clk,
  input  logic                                          reset,
  input  logic                                          rx_csr_valid,
  input  logic [CSR_HDR_W-1:0]                          rx_csr_header,
  input  logic [CSR_DATA_W-1:0]                         rx_csr_data,
  input  logic                                          soft_clear,
  output logic [N_REG64*64-1:0]                         reg_value,
  output logic [N_REG64-1:0]                            reg_valid,
  output logic                                          afu_en,
  output logic [((N_PULSE > 0) ? N_PULSE : 1)*PULSE_W-1:0] pulse_value,
  output logic [((N_PULSE > 0) ? N_PULSE : 1)-1:0]       pulse_strobe,
  output logic [15:0]                                   unmatched_cnt
);

  localparam int NP_W = (N_PULSE > 0) ? N_PULSE : 1;

  logic [CSR_DWADR_W-1:0] dw_addr;
  logic                   unused_hdr_bits;

  logic [N_REG64-1:0] lo_we;
  logic [N_REG64-1:0] hi_we;
  logic [NP_W-1:0]    pulse_hit;
  logic               en_hit;
  logic               any_hit;

  logic                  afu_en_d, afu_en_q;
  logic [15:0]           cnt_d,    cnt_q;
  t_CSR_PULSE [NP_W-1:0] pulse_d,  pulse_q;
  logic                  unused_pulse_bits;

  assign dw_addr         = rx_csr_header[CSR_DWADR_W-1:0];
  assign unused_hdr_bits = ^rx_csr_header[CSR_HDR_W-1:CSR_DWADR_W];

  // Address decode: one hit line per CSR, all gated by rx_csr_valid so an
  // idle bus can never disturb state. any_hit feeds the miss counter.
  always_comb begin
    lo_we     = '0;
    hi_we     = '0;
    pulse_hit = '0;
    en_hit    = rx_csr_valid &&
                csr_addr_match(dw_addr, enable_offset(CSR_BASE, N_REG64));

    for (int i = 0; i < N_REG64; i++) begin
      lo_we[i] = rx_csr_valid && csr_addr_match(dw_addr, reg_lo_offset(CSR_BASE, i));
      hi_we[i] = rx_csr_valid && csr_addr_match(dw_addr, reg_hi_offset(CSR_BASE, i));
    end

    for (int j = 0; j < N_PULSE; j++) begin
      pulse_hit[j] = rx_csr_valid &&
                     csr_addr_match(dw_addr, pulse_offset(CSR_BASE, N_REG64, j));
    end

    any_hit = (|lo_we) || (|hi_we) || en_hit || (|pulse_hit);
  end

  // Enable bit, miss counter and pulse next-state. Pulses are rebuilt from
  // scratch every cycle, which gives the self-clear for free and lets
  // back-to-back writes to the same pulse produce consecutive strobes.
  always_comb begin
    afu_en_d = afu_en_q;
    cnt_d    = cnt_q;
    pulse_d  = '0;

    if (en_hit) begin
      afu_en_d = rx_csr_data[0];
    end
    if (soft_clear) begin
      afu_en_d = 1'b0;
    end

    if (rx_csr_valid && !any_hit && (cnt_q != 16'hffff)) begin
      cnt_d = cnt_q + 16'd1;
    end

    for (int j = 0; j < NP_W; j++) begin
      if (pulse_hit[j]) begin
        pulse_d[j].strobe  = 1'b1;
        pulse_d[j].payload = PULSE_W_MAX'(rx_csr_data);
      end
    end
  end

  // Bank-level state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      afu_en_q <= 1'b0;
      cnt_q    <= '0;
      pulse_q  <= '0;
    end else begin
      afu_en_q <= afu_en_d;
      cnt_q    <= cnt_d;
      pulse_q  <= pulse_d;
    end
  end

  // One split register per CSR pair.
  for (genvar i = 0; i < N_REG64; i++) begin : g_pair
    qa_drv_csr_pair u_pair (
      .clk        (clk),
      .reset      (reset),
      .lo_we      (lo_we[i]),
      .hi_we      (hi_we[i]),
      .soft_clear (soft_clear),
      .wr_data    (rx_csr_data),
      .value      (reg_value[i*64 +: 64]),
      .valid      (reg_valid[i])
    );
  end

  // The pulse record carries a full-width payload; only PULSE_W bits leave.
  for (genvar j = 0; j < NP_W; j++) begin : g_pulse_out
    assign pulse_value[j*PULSE_W +: PULSE_W] = pulse_q[j].payload[PULSE_W-1:0];
    assign pulse_strobe[j]                   = pulse_q[j].strobe;
  end

  assign unused_pulse_bits = ^pulse_q;
  assign afu_en            = afu_en_q;
  assign unmatched_cnt     = cnt_q;

endmodule

// File: tb/tb_qa_drv_csr_bank.sv
// ---------------------------------------------------------------------------
// tb_qa_drv_csr_bank
//   Directed bench for qa_drv_csr_bank with default parameters. Stimulus
//   pushes hand-computed expectations, tagged with the cycle they are due,
//   into a scoreboard queue; a separate monitor pops and compares them, and
//   matches every pulse_strobe it sees against a queue of expected pulses.
// ---------------------------------------------------------------------------
module tb_qa_drv_csr_bank;

  localparam int N_REG64 = 4;
  localparam int N_PULSE = 2;
  localparam int PULSE_W = 8;

  localparam int K_VAL  = 0;
  localparam int K_VLD  = 1;
  localparam int K_EN   = 2;
  localparam int K_CNT  = 3;
  localparam int K_STB  = 4;
  localparam int K_PVAL = 5;
  localparam int K_VLDV = 6;

  logic                         clk = 1'b0;
  logic                         reset = 1'b1;
  logic                         rx_csr_valid = 1'b0;
  logic [17:0]                  rx_csr_header = '0;
  logic [31:0]                  rx_csr_data = '0;
  logic                         soft_clear = 1'b0;
  logic [N_REG64*64-1:0]        reg_value;
  logic [N_REG64-1:0]           reg_valid;
  logic                         afu_en;
  logic [N_PULSE*PULSE_W-1:0]   pulse_value;
  logic [N_PULSE-1:0]           pulse_strobe;
  logic [15:0]                  unmatched_cnt;

  qa_drv_csr_bank #(
    .N_REG64  (N_REG64),
    .N_PULSE  (N_PULSE),
    .PULSE_W  (PULSE_W),
    .CSR_BASE (16'h1a00)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .rx_csr_valid  (rx_csr_valid),
    .rx_csr_header (rx_csr_header),
    .rx_csr_data   (rx_csr_data),
    .soft_clear    (soft_clear),
    .reg_value     (reg_value),
    .reg_valid     (reg_valid),
    .afu_en        (afu_en),
    .pulse_value   (pulse_value),
    .pulse_strobe  (pulse_strobe),
    .unmatched_cnt (unmatched_cnt)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int unsigned cyc;
    int          kind;
    int          idx;
    logic [63:0] exp;
    string       name;
  } chk_t;

  typedef struct {
    int unsigned        cyc;
    int                 idx;
    logic [PULSE_W-1:0] payload;
  } pls_t;

  chk_t chk_q[$];
  pls_t pls_q[$];
  int   total = 0;
  int   bad   = 0;

  // Single comparison point; every check in the bench lands here.
  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [63:0] sample(input int kind, input int idx);
    case (kind)
      K_VAL:   return reg_value[idx*64 +: 64];
      K_VLD:   return 64'(reg_valid[idx]);
      K_EN:    return 64'(afu_en);
      K_CNT:   return 64'(unmatched_cnt);
      K_STB:   return 64'(pulse_strobe);
      K_PVAL:  return 64'(pulse_value);
      K_VLDV:  return 64'(reg_valid);
      default: return '1;
    endcase
  endfunction

  // Expectation for the outputs seen after the next rising edge.
  task automatic expectAt(input string name, input int kind, input int idx, input logic [63:0] exp);
    chk_t c;
    c.cyc  = cyc + 1;
    c.kind = kind;
    c.idx  = idx;
    c.exp  = exp;
    c.name = name;
    chk_q.push_back(c);
  endtask

  task automatic expectPulse(input int idx, input logic [PULSE_W-1:0] payload);
    pls_t p;
    p.cyc     = cyc + 1;
    p.idx     = idx;
    p.payload = payload;
    pls_q.push_back(p);
  endtask

  task automatic driveNow(input logic v, input logic [15:0] addr, input logic [31:0] data,
                          input logic sc, input logic [3:0] junk);
    rx_csr_valid  = v;
    rx_csr_header = {junk, addr[15:2]};
    rx_csr_data   = data;
    soft_clear    = sc;
  endtask

  task automatic applyStimulus(input logic v, input logic [15:0] addr, input logic [31:0] data,
                               input logic sc, input logic [3:0] junk);
    @(negedge clk);
    driveNow(v, addr, data, sc, junk);
  endtask

  task automatic idle();
    applyStimulus(1'b0, 16'h0000, 32'h0, 1'b0, 4'h0);
  endtask

  // Monitor: drains due scoreboard entries and pairs each strobe with the
  // oldest expected pulse.
  initial begin
    chk_t c;
    pls_t p;
    forever begin
      @(negedge clk);
      while (chk_q.size() > 0 && chk_q[0].cyc <= cyc) begin
        c = chk_q.pop_front();
        if (c.cyc != cyc) checkOutput({c.name, "_late"}, 64'(cyc), 64'(c.cyc));
        else              checkOutput(c.name, sample(c.kind, c.idx), c.exp);
      end
      for (int j = 0; j < N_PULSE; j++) begin
        if (pulse_strobe[j] === 1'b1) begin
          if (pls_q.size() == 0) begin
            checkOutput("unexpected_strobe", 64'(pulse_strobe[j]), 64'd0);
          end else begin
            p = pls_q.pop_front();
            checkOutput("pulse_index", 64'(j), 64'(p.idx));
            checkOutput("pulse_payload", 64'(pulse_value[j*PULSE_W +: PULSE_W]), 64'(p.payload));
            checkOutput("pulse_cycle", 64'(cyc), 64'(p.cyc));
          end
        end
      end
    end
  end

  initial begin
    #900000;
    bad++;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Reset values while reset is held.
    repeat (2) @(negedge clk);
    expectAt("rst_val0", K_VAL, 0, 64'h0);
    expectAt("rst_val3", K_VAL, 3, 64'h0);
    expectAt("rst_vldv", K_VLDV, 0, 64'h0);
    expectAt("rst_en",   K_EN,   0, 64'h0);
    expectAt("rst_cnt",  K_CNT,  0, 64'h0);
    expectAt("rst_stb",  K_STB,  0, 64'h0);
    expectAt("rst_pval", K_PVAL, 0, 64'h0);
    @(negedge clk);
    reset = 1'b0;

    // Split 64-bit write; header spare bits set on the commit.
    applyStimulus(1'b1, 16'h1a00, 32'h1111_2222, 1'b0, 4'h0);
    expectAt("r0_vld_after_lo", K_VLD, 0, 64'h0);
    expectAt("r0_val_after_lo", K_VAL, 0, 64'h0);
    applyStimulus(1'b1, 16'h1a04, 32'h3333_4444, 1'b0, 4'hf);
    expectAt("r0_val", K_VAL, 0, 64'h3333_4444_1111_2222);
    expectAt("r0_vld", K_VLD, 0, 64'h1);

    // High write with no preceding low uses the reset staging value.
    applyStimulus(1'b1, 16'h1a0c, 32'haaaa_0000, 1'b0, 4'h0);
    expectAt("r1_val_hi_only", K_VAL, 1, 64'haaaa_0000_0000_0000);
    expectAt("r1_vld_hi_only", K_VLD, 1, 64'h1);
    expectAt("r0_val_kept", K_VAL, 0, 64'h3333_4444_1111_2222);
    applyStimulus(1'b1, 16'h1a08, 32'h5555_6666, 1'b0, 4'h0);
    expectAt("r1_vld_lo_clears", K_VLD, 1, 64'h0);
    expectAt("r1_val_lo_keeps", K_VAL, 1, 64'haaaa_0000_0000_0000);
    expectAt("vldv_after_lo", K_VLDV, 0, 64'h1);
    applyStimulus(1'b1, 16'h1a0c, 32'h7777_8888, 1'b0, 4'h0);
    expectAt("r1_val_commit", K_VAL, 1, 64'h7777_8888_5555_6666);
    expectAt("r1_vld_commit", K_VLD, 1, 64'h1);

    // Enable takes bit 0 only.
    applyStimulus(1'b1, 16'h1a20, 32'hffff_fffe, 1'b0, 4'h0);
    expectAt("en_bit0_zero", K_EN, 0, 64'h0);
    applyStimulus(1'b1, 16'h1a20, 32'h0000_0001, 1'b0, 4'h0);
    expectAt("en_set", K_EN, 0, 64'h1);
    idle();
    expectAt("en_hold", K_EN, 0, 64'h1);
    expectAt("vldv_hold", K_VLDV, 0, 64'h3);
    expectAt("cnt_zero", K_CNT, 0, 64'h0);
    expectAt("stb_idle", K_STB, 0, 64'h0);

    // Back-to-back pulses on pulse 0, then pulse 1.
    applyStimulus(1'b1, 16'h1a24, 32'h1234_005a, 1'b0, 4'h0);
    expectPulse(0, 8'h5a);
    expectAt("p0_stb_first", K_STB, 0, 64'h1);
    applyStimulus(1'b1, 16'h1a24, 32'h0000_00a5, 1'b0, 4'h0);
    expectPulse(0, 8'ha5);
    expectAt("p0_stb_second", K_STB, 0, 64'h1);
    expectAt("p0_pval_second", K_PVAL, 0, 64'h00a5);
    idle();
    expectAt("p0_stb_done", K_STB, 0, 64'h0);
    expectAt("p0_pval_done", K_PVAL, 0, 64'h0);
    applyStimulus(1'b1, 16'h1a28, 32'h0000_003c, 1'b0, 4'h0);
    expectPulse(1, 8'h3c);
    expectAt("p1_stb", K_STB, 0, 64'h2);
    expectAt("p1_pval", K_PVAL, 0, 64'h3c00);
    idle();
    expectAt("p1_stb_done", K_STB, 0, 64'h0);

    // Writes that hit nothing.
    applyStimulus(1'b1, 16'h1a2c, 32'h1, 1'b0, 4'h0);
    expectAt("cnt_1", K_CNT, 0, 64'h1);
    applyStimulus(1'b1, 16'h1a30, 32'h1, 1'b0, 4'h0);
    expectAt("cnt_2", K_CNT, 0, 64'h2);
    applyStimulus(1'b1, 16'h2a00, 32'h1, 1'b0, 4'h0);
    expectAt("cnt_3", K_CNT, 0, 64'h3);
    expectAt("r0_val_miss", K_VAL, 0, 64'h3333_4444_1111_2222);
    applyStimulus(1'b0, 16'h1a20, 32'h0, 1'b0, 4'h0);
    expectAt("en_no_valid", K_EN, 0, 64'h1);
    expectAt("cnt_no_valid", K_CNT, 0, 64'h3);

    // soft_clear on its own.
    applyStimulus(1'b0, 16'h0000, 32'h0, 1'b1, 4'h0);
    expectAt("sc_vldv", K_VLDV, 0, 64'h0);
    expectAt("sc_en", K_EN, 0, 64'h0);
    expectAt("sc_val0", K_VAL, 0, 64'h3333_4444_1111_2222);
    expectAt("sc_val1", K_VAL, 1, 64'h7777_8888_5555_6666);
    expectAt("sc_cnt", K_CNT, 0, 64'h3);

    // soft_clear racing writes.
    applyStimulus(1'b1, 16'h1a14, 32'hbeef_0000, 1'b0, 4'h0);
    expectAt("r2_val", K_VAL, 2, 64'hbeef_0000_0000_0000);
    expectAt("r2_vld", K_VLD, 2, 64'h1);
    applyStimulus(1'b1, 16'h1a20, 32'h1, 1'b0, 4'h0);
    expectAt("en_reset", K_EN, 0, 64'h1);
    applyStimulus(1'b1, 16'h1a10, 32'h1, 1'b1, 4'h0);
    expectAt("sc_lo_en", K_EN, 0, 64'h0);
    expectAt("sc_lo_vldv", K_VLDV, 0, 64'h0);
    applyStimulus(1'b1, 16'h1a14, 32'h1234_5678, 1'b1, 4'h0);
    expectAt("sc_hi_val2", K_VAL, 2, 64'h1234_5678_0000_0001);
    expectAt("sc_hi_vldv", K_VLDV, 0, 64'h0);
    applyStimulus(1'b1, 16'h1a20, 32'h1, 1'b1, 4'h0);
    expectAt("sc_en_write", K_EN, 0, 64'h0);
    applyStimulus(1'b1, 16'h1a1c, 32'h9, 1'b0, 4'h0);
    expectAt("r3_val", K_VAL, 3, 64'h0000_0009_0000_0000);
    expectAt("r3_vldv", K_VLDV, 0, 64'h8);

    // Reset between low and high halves discards the staged low word.
    applyStimulus(1'b1, 16'h1a00, 32'hdead_beef, 1'b0, 4'h0);
    expectAt("r0_val_staged", K_VAL, 0, 64'h3333_4444_1111_2222);
    @(negedge clk);
    reset = 1'b1;
    driveNow(1'b0, 16'h0000, 32'h0, 1'b0, 4'h0);
    expectAt("rst2_val0", K_VAL, 0, 64'h0);
    expectAt("rst2_val3", K_VAL, 3, 64'h0);
    expectAt("rst2_cnt", K_CNT, 0, 64'h0);
    expectAt("rst2_vldv", K_VLDV, 0, 64'h0);
    @(negedge clk);
    reset = 1'b0;
    driveNow(1'b1, 16'h1a04, 32'h0000_0001, 1'b0, 4'h0);
    expectAt("r0_post_rst", K_VAL, 0, 64'h0000_0001_0000_0000);
    expectAt("r0_vld_post_rst", K_VLD, 0, 64'h1);
    idle();

    // Miss counter saturation.
    for (int i = 0; i < 70000; i++) begin
      applyStimulus(1'b1, 16'h0000, 32'(i), 1'b0, 4'h0);
      if (i == 0)     expectAt("sat_first", K_CNT, 0, 64'h1);
      if (i == 65533) expectAt("sat_fffe", K_CNT, 0, 64'hfffe);
      if (i == 65534) expectAt("sat_ffff", K_CNT, 0, 64'hffff);
    end
    expectAt("sat_end", K_CNT, 0, 64'hffff);
    idle();
    expectAt("sat_hold", K_CNT, 0, 64'hffff);
    expectAt("sat_val0", K_VAL, 0, 64'h0000_0001_0000_0000);
    repeat (3) idle();

    checkOutput("scoreboard_drained", 64'(chk_q.size()), 64'd0);
    checkOutput("pulses_drained", 64'(pls_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
